// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder and its helpers:
// bus widths, reset/bubble polarities, the NOP encoding and FSM states.
package inst_fetch_resp_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam logic  RST_ENABLE   = 1'b0;
  localparam logic  BBL_ENABLE   = 1'b1;
  localparam logic  BBL_DISABLE  = 1'b0;
  localparam inst_t NOP_ENCODING = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } fetch_state_t;

  // Instruction words are 4-byte aligned; only the two low address bits matter.
  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait-cycle counter for memory handshakes. load clears it,
// en advances it, expire flags the last permitted wait cycle. Shared with
// the data-memory side, so it knows nothing about instruction fetch.
module fetch_timeout_ctr
  import inst_fetch_resp_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Count wait cycles, holding at the terminal count instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != TERM_CNT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (cnt == TERM_CNT);

endmodule

// File: rtl/inst_fetch_resp.sv
// Responder side of the PC/instruction-fetch interface. Takes pc_i/ce_i,
// runs a req/ack transaction against a multi-cycle instruction memory,
// returns the word to IF/ID and holds the PC (bbl_o) until it is delivered.
// Optional build macro INST_FETCH_LAST_HIT_EN adds a one-entry last-fetch
// register that serves a repeated address without touching memory.
//
// state  | meaning
// S_IDLE | no fetch in flight; next edge with ce_i=1 starts one
// S_WAIT | request outstanding, waiting for mem_ack_i or timeout
// S_RESP | inst_o/inst_valid_o presented for one cycle; PC advances
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int    TIMEOUT_CYC = 16,
  parameter inst_t NOP_INST    = NOP_ENCODING
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        branch_flag_i,
  output logic        bbl_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  fetch_state_t state;
  logic         discard_q;
  logic         tmo_load;
  logic         tmo_en;
  logic         tmo_expire;
  logic         ack_good;
  logic         last_hit;
  inst_t        hit_inst;

  // Data is only worth delivering if nothing invalidated the fetch while it
  // was in flight, including a flush or disable arriving with the ack itself.
  assign ack_good = ~discard_q & ~branch_flag_i & ce_i;

  assign tmo_load = (state == S_IDLE);
  assign tmo_en   = (state == S_WAIT) & ~mem_ack_i;

  fetch_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (tmo_load),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

`ifdef INST_FETCH_LAST_HIT_EN
  logic       last_valid;
  inst_addr_t last_addr;
  inst_t      last_inst;

  assign last_hit = last_valid & (last_addr == pc_i);
  assign hit_inst = last_inst;

  // Remember the most recent good fetch; any disturbance to the fetch
  // stream invalidates it.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      last_valid <= 1'b0;
      last_addr  <= '0;
      last_inst  <= NOP_INST;
    end else if (~ce_i | branch_flag_i | fetch_err_o) begin
      last_valid <= 1'b0;
    end else if ((state == S_WAIT) && mem_ack_i && ack_good) begin
      last_valid <= 1'b1;
      last_addr  <= mem_addr_o;
      last_inst  <= mem_rdata_i;
    end
  end
`else
  assign last_hit = 1'b0;
  assign hit_inst = NOP_INST;
`endif

  // The PC may only advance on the edge that ends the response cycle.
  assign bbl_o = (ce_i && (state != S_RESP)) ? BBL_ENABLE : BBL_DISABLE;

  // Fetch sequencer with registered memory and response outputs.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state        <= S_IDLE;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      fetch_err_o  <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ce_i) begin
            if (!is_aligned(pc_i[1:0])) begin
              // Misaligned addresses never reach memory.
              fetch_err_o  <= 1'b1;
              inst_o       <= NOP_INST;
              inst_valid_o <= 1'b1;
              state        <= S_RESP;
            end else if (last_hit) begin
              inst_o       <= hit_inst;
              inst_valid_o <= 1'b1;
              state        <= S_RESP;
            end else begin
              mem_addr_o <= pc_i;
              mem_req_o  <= 1'b1;
              discard_q  <= 1'b0;
              state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            discard_q <= 1'b0;
            if (ack_good) begin
              inst_o       <= mem_rdata_i;
              inst_valid_o <= 1'b1;
              state        <= S_RESP;
            end else begin
              // Stale data is dropped; IDLE refetches at the current pc_i.
              state <= S_IDLE;
            end
          end else if (tmo_expire) begin
            mem_req_o    <= 1'b0;
            fetch_err_o  <= 1'b1;
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b1;
            discard_q    <= 1'b0;
            state        <= S_RESP;
          end else if (branch_flag_i || !ce_i) begin
            // The request stays up until acked; only its result is marked stale.
            discard_q <= 1'b1;
          end
        end
        S_RESP: begin
          inst_valid_o <= 1'b0;
          fetch_err_o  <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Self-checking bench for inst_fetch_resp. The bench plays the instruction
// memory and predicts each fetch's outcome at transaction level: whether it
// reaches memory, whether it is discarded, times out, errors or hits the
// last-fetch register (when INST_FETCH_LAST_HIT_EN is defined).
module tb_inst_fetch_resp;

  localparam int          TIMEOUT_CYC = 16;
  localparam logic [31:0] NOP         = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        branch_flag_i;
  logic        bbl_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        fetch_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int vec  = 0;
  int errs = 0;

  // Reference view of the one-entry last-fetch register.
  bit          m_last_valid = 1'b0;
  logic [31:0] m_last_addr  = '0;
  logic [31:0] m_last_inst  = '0;

  inst_fetch_resp #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .NOP_INST    (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .ce_i          (ce_i),
    .branch_flag_i (branch_flag_i),
    .bbl_o         (bbl_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o),
    .fetch_err_o   (fetch_err_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One fetch from IDLE. ack_cyc/flush_cyc/drop_cyc index WAIT cycles from 0
  // (negative or out of range means never); drop holds ce_i low until the end.
  task automatic run_fetch(input logic [31:0] pc, input int ack_cyc, input int flush_cyc,
                           input int drop_cyc, input logic [31:0] rdata,
                           input bit resp_branch, input string tag);
    bit          mis, hit, disc, done, resp, exp_err;
    logic [31:0] exp_inst;
    mis      = (pc[1:0] != 2'b00);
    hit      = 1'b0;
`ifdef INST_FETCH_LAST_HIT_EN
    hit      = !mis && m_last_valid && (m_last_addr == pc);
`endif
    resp     = 1'b0;
    exp_err  = 1'b0;
    exp_inst = NOP;
    pc_i = pc; ce_i = 1'b1; branch_flag_i = 1'b0; mem_ack_i = 1'b0;
    step();
    if (mis || hit) begin
      resp     = 1'b1;
      exp_err  = mis;
      exp_inst = mis ? NOP : m_last_inst;
    end else begin
      disc = 1'b0;
      done = 1'b0;
      for (int k = 0; !done && k < TIMEOUT_CYC; k++) begin
        branch_flag_i = (k == flush_cyc);
        ce_i          = !(drop_cyc >= 0 && k >= drop_cyc);
        if (branch_flag_i || !ce_i) begin
          disc         = 1'b1;
          m_last_valid = 1'b0;
        end
        mem_ack_i   = (k == ack_cyc);
        mem_rdata_i = mem_ack_i ? rdata : $urandom();
        #1;
        vec++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== pc || bbl_o !== ce_i || inst_valid_o !== 1'b0) begin
          errs++;
          $display("FAIL %s wait%0d: req=%b addr=%h bbl=%b vld=%b, want req=1 addr=%h bbl=%b vld=0",
                   tag, k, mem_req_o, mem_addr_o, bbl_o, inst_valid_o, pc, ce_i);
        end
        step();
        if (k == ack_cyc) begin
          done = 1'b1;
          if (disc) begin
            vec++;
            if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || fetch_err_o !== 1'b0 || bbl_o !== ce_i) begin
              errs++;
              $display("FAIL %s discard: req=%b vld=%b err=%b bbl=%b, want req=0 vld=0 err=0 bbl=%b",
                       tag, mem_req_o, inst_valid_o, fetch_err_o, bbl_o, ce_i);
            end
          end else begin
            resp         = 1'b1;
            exp_inst     = rdata;
            m_last_valid = 1'b1;
            m_last_addr  = pc;
            m_last_inst  = rdata;
          end
        end else if (k == TIMEOUT_CYC - 1) begin
          done     = 1'b1;
          resp     = 1'b1;
          exp_err  = 1'b1;
          exp_inst = NOP;
        end
      end
      mem_ack_i     = 1'b0;
      branch_flag_i = 1'b0;
    end
    if (resp) begin
      vec++;
      if (inst_valid_o !== 1'b1 || fetch_err_o !== exp_err || inst_o !== exp_inst ||
          mem_req_o !== 1'b0 || bbl_o !== 1'b0) begin
        errs++;
        $display("FAIL %s resp: vld=%b err=%b inst=%h req=%b bbl=%b, want vld=1 err=%b inst=%h req=0 bbl=0",
                 tag, inst_valid_o, fetch_err_o, inst_o, mem_req_o, bbl_o, exp_err, exp_inst);
      end
      if (exp_err) m_last_valid = 1'b0;
      branch_flag_i = resp_branch;
      ce_i          = 1'b1;
      if (resp_branch) m_last_valid = 1'b0;
      step();
      branch_flag_i = 1'b0;
      vec++;
      if (inst_valid_o !== 1'b0 || fetch_err_o !== 1'b0 || mem_req_o !== 1'b0 || bbl_o !== 1'b1) begin
        errs++;
        $display("FAIL %s after_resp: vld=%b err=%b req=%b bbl=%b, want vld=0 err=0 req=0 bbl=1",
                 tag, inst_valid_o, fetch_err_o, mem_req_o, bbl_o);
      end
    end
  endtask

  task automatic test_idle(input int n);
    ce_i = 1'b0; branch_flag_i = 1'b0; mem_ack_i = 1'b0;
    m_last_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      vec++;
      if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || bbl_o !== 1'b0) begin
        errs++;
        $display("FAIL idle: req=%b vld=%b bbl=%b, want 0 0 0", mem_req_o, inst_valid_o, bbl_o);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ce_i = 1'b1; pc_i = 32'h0; branch_flag_i = 1'b0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    m_last_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++;
      if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || inst_o !== NOP ||
          inst_valid_o !== 1'b0 || fetch_err_o !== 1'b0) begin
        errs++;
        $display("FAIL reset: req=%b addr=%h inst=%h vld=%b err=%b, want all zero/NOP",
                 mem_req_o, mem_addr_o, inst_o, inst_valid_o, fetch_err_o);
      end
    end
    rst = 1'b1;
    run_fetch(32'h0, 0, -1, -1, 32'h1111_0000, 1'b0, "first_after_reset");
  endtask

  task automatic test_reset_mid();
    pc_i = 32'h500; ce_i = 1'b1; branch_flag_i = 1'b0; mem_ack_i = 1'b0;
    step();
    vec++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h500) begin
      errs++;
      $display("FAIL reset_mid req: req=%b addr=%h, want 1 00000500", mem_req_o, mem_addr_o);
    end
    rst = 1'b0;
    step();
    m_last_valid = 1'b0;
    vec++;
    if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP || mem_addr_o !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid drop: req=%b vld=%b inst=%h addr=%h, want 0 0 NOP 0",
               mem_req_o, inst_valid_o, inst_o, mem_addr_o);
    end
    rst = 1'b1;
    run_fetch(32'h504, 2, -1, -1, 32'h5555_AAAA, 1'b0, "after_mid_reset");
  endtask

  task automatic test_basic();
    run_fetch(32'h100, 1, -1, -1, 32'h2401_0005, 1'b0, "basic_100");
    run_fetch(32'h180, 0, -1, -1, 32'hCAFE_F00D, 1'b0, "min_latency");
  endtask

  task automatic test_flush();
    run_fetch(32'h104, 1, 0, -1, 32'hDEAD_BEEF, 1'b0, "flush_104");
    run_fetch(32'h200, 0, -1, -1, 32'h0000_0200, 1'b0, "refetch_200");
    run_fetch(32'h204, 2, 2, -1, 32'hBAD0_0001, 1'b0, "flush_on_ack");
    run_fetch(32'h208, 1, -1, -1, 32'h0000_0208, 1'b0, "after_flush_ack");
  endtask

  task automatic test_ce_drop();
    run_fetch(32'h400, 3, -1, 1, 32'hBAD0_0400, 1'b0, "ce_drop");
    run_fetch(32'h404, 1, -1, -1, 32'h0000_0404, 1'b0, "after_ce_drop");
  endtask

  task automatic test_timeout();
    run_fetch(32'h108, 99, -1, -1, 32'h0, 1'b0, "timeout_108");
    run_fetch(32'h10C, TIMEOUT_CYC - 1, -1, -1, 32'h0000_010C, 1'b0, "ack_at_limit");
  endtask

  task automatic test_misaligned();
    run_fetch(32'h102, 0, -1, -1, 32'h0, 1'b0, "misaligned_102");
    run_fetch(32'h111, 0, -1, -1, 32'h0, 1'b0, "misaligned_111");
  endtask

  task automatic test_last_hit();
    test_idle(1);
    run_fetch(32'h300, 1, -1, -1, 32'h3000_0300, 1'b0, "hit_first");
    run_fetch(32'h300, 1, -1, -1, 32'h3333_3333, 1'b1, "hit_second");
    run_fetch(32'h300, 1, -1, -1, 32'h3000_0301, 1'b0, "hit_after_branch");
    run_fetch(32'h300, 1, -1, -1, 32'h3000_0302, 1'b0, "hit_again");
  endtask

  task automatic test_random();
    logic [31:0] pc;
    int          ack, fl, dr;
    bit          rb;
    for (int i = 0; i < 60; i++) begin
      pc = 32'h1000 + (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      ack = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 4));
      fl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      dr  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      rb  = ($urandom_range(0, 7) == 0);
      run_fetch(pc, ack, fl, dr, $urandom(), rb, "random");
      if ($urandom_range(0, 7) == 0) test_idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_ce_drop();
    test_timeout();
    test_misaligned();
    test_last_hit();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
